// File: rtl/rsa_exp_arbiter.sv
// Round-robin arbiter and job sequencer sharing one modular-exponentiation engine
// between NREQ requesters: grant, capture exponent, clear/start engine, return result.
module rsa_exp_arbiter #(
  parameter int NREQ       = 4,
  parameter int BITLEN     = 512,
  parameter int LOG_BITLEN = 9,
  parameter int TIMEOUT    = 2000000,
  parameter int TBITS      = 21
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [BITLEN-1:0]     e_in,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  err,
  output logic [BITLEN-1:0]     ans,
  output logic                  exp_rst,
  output logic                  exp_start,
  output logic [BITLEN-1:0]     exp_e,
  output logic [LOG_BITLEN-1:0] exp_e_idx,
  input  logic                  exp_stop,
  input  logic [BITLEN-1:0]     exp_ans
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SCAN = 3'd2,
    S_CLR  = 3'd3,
    S_RUN  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t                state_r;
  logic [IW-1:0]         last_r;
  logic [IW-1:0]         gidx_r;
  logic [IW-1:0]         pick_idx_s;
  logic [IW-1:0]         cand_s;
  logic                  pick_vld_s;
  logic [TBITS-1:0]      timer_r;
  logic                  stop_q_r;
  logic                  rise_s;
  logic                  small_s;
  logic [LOG_BITLEN-1:0] msb_s;

  // Highest set bit position; callers guarantee at least bit 1 is reachable.
  function automatic logic [LOG_BITLEN-1:0] msb_index(input logic [BITLEN-1:0] v);
    logic [LOG_BITLEN-1:0] idx;
    idx = {LOG_BITLEN{1'b0}};
    for (int i = 0; i < BITLEN; i++) begin
      if (v[i]) begin
        idx = LOG_BITLEN'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  assign msb_s   = msb_index(exp_e);
  assign small_s = ~|exp_e[BITLEN-1:1];
  assign rise_s  = exp_stop & ~stop_q_r;

  // Round-robin pick: scan downward so the nearest index after last_r wins.
  always_comb begin
    pick_vld_s = 1'b0;
    pick_idx_s = last_r;
    cand_s     = last_r;
    for (int k = NREQ; k >= 1; k--) begin
      cand_s = IW'((32'(last_r) + k) % NREQ);
      if (req[cand_s]) begin
        pick_vld_s = 1'b1;
        pick_idx_s = cand_s;
      end else begin
        pick_vld_s = pick_vld_s;
      end
    end
  end

  // Job sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      last_r    <= IW'(NREQ - 1);
      gidx_r    <= {IW{1'b0}};
      timer_r   <= {TBITS{1'b0}};
      stop_q_r  <= 1'b0;
      gnt       <= {NREQ{1'b0}};
      done      <= {NREQ{1'b0}};
      err       <= 1'b0;
      ans       <= {BITLEN{1'b0}};
      exp_rst   <= 1'b1;
      exp_start <= 1'b0;
      exp_e     <= {BITLEN{1'b0}};
      exp_e_idx <= {LOG_BITLEN{1'b0}};
    end else begin
      done      <= {NREQ{1'b0}};
      err       <= 1'b0;
      exp_rst   <= 1'b0;
      exp_start <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (pick_vld_s) begin
            gnt     <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx_s;
            gidx_r  <= pick_idx_s;
            state_r <= S_LOAD;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_LOAD: begin
          exp_e   <= e_in;
          state_r <= S_SCAN;
        end
        S_SCAN: begin
          // An exponent below 2 would leave the engine with e_idx 0, so reject it.
          if (small_s) begin
            done    <= gnt;
            err     <= 1'b1;
            gnt     <= {NREQ{1'b0}};
            last_r  <= gidx_r;
            state_r <= S_DONE;
          end else begin
            exp_e_idx <= msb_s;
            exp_rst   <= 1'b1;
            state_r   <= S_CLR;
          end
        end
        S_CLR: begin
          exp_start <= 1'b1;
          timer_r   <= {TBITS{1'b0}};
          stop_q_r  <= 1'b0;
          state_r   <= S_RUN;
        end
        S_RUN: begin
          stop_q_r <= exp_stop;
          if (rise_s) begin
            done    <= gnt;
            ans     <= exp_ans;
            gnt     <= {NREQ{1'b0}};
            last_r  <= gidx_r;
            state_r <= S_DONE;
          end else if (timer_r == TBITS'(TIMEOUT - 1)) begin
            done    <= gnt;
            err     <= 1'b1;
            gnt     <= {NREQ{1'b0}};
            last_r  <= gidx_r;
            state_r <= S_DONE;
          end else begin
            timer_r <= timer_r + TBITS'(1);
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          gnt     <= {NREQ{1'b0}};
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_exp_arbiter.sv
// Scoreboard bench for rsa_exp_arbiter with a stub exponentiation engine.
module tb_rsa_exp_arbiter;

  localparam int NREQ = 4;
  localparam int BL   = 64;
  localparam int LBL  = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [BL-1:0]   e_in;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] done;
  logic            err;
  logic [BL-1:0]   ans;
  logic            exp_rst;
  logic            exp_start;
  logic [BL-1:0]   exp_e;
  logic [LBL-1:0]  exp_e_idx;
  logic            exp_stop;
  logic [BL-1:0]   exp_ans;

  typedef struct {
    logic [NREQ-1:0] d;
    logic            e;
    logic [BL-1:0]   a;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_start  = 0;
  int   n_erst   = 0;
  int   stub_lat = 0;
  int   st_cnt   = 0;
  logic st_run   = 1'b0;

  rsa_exp_arbiter #(
    .NREQ(NREQ), .BITLEN(BL), .LOG_BITLEN(LBL), .TIMEOUT(100), .TBITS(7)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .e_in(e_in), .gnt(gnt), .done(done),
    .err(err), .ans(ans), .exp_rst(exp_rst), .exp_start(exp_start),
    .exp_e(exp_e), .exp_e_idx(exp_e_idx), .exp_stop(exp_stop), .exp_ans(exp_ans)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stub engine: stop rises stub_lat cycles after the start cycle and sticks until cleared.
  always @(posedge clk) begin
    if (exp_rst) begin
      exp_stop <= 1'b0;
      st_run   <= 1'b0;
      st_cnt   <= 0;
    end else if (exp_start) begin
      st_run <= 1'b1;
      st_cnt <= 1;
    end else if (st_run && stub_lat != 0 && st_cnt == stub_lat - 1) begin
      exp_stop <= 1'b1;
      st_run   <= 1'b0;
    end else if (st_run) begin
      st_cnt <= st_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done == 4'b0000 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("wait_done_bound", 64'(done != 4'b0000), 64'd1);
  endtask

  task automatic wait_gnt(input int budget);
    int n;
    n = 0;
    while (gnt == 4'b0000 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("wait_gnt_bound", 64'(gnt != 4'b0000), 64'd1);
  endtask

  // Monitor: scoreboard compare on every done pulse, grant one-hot, pulse counters.
  always @(negedge clk) begin
    exp_t x;
    if (exp_start) n_start++;
    if (exp_rst) n_erst++;
    if (gnt != 4'b0000) check_eq("gnt_onehot", 64'($onehot(gnt)), 64'd1);
    if (done != 4'b0000) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 64'(done), 64'd0);
      end else begin
        x = sb.pop_front();
        check_eq("sb_done", 64'(done), 64'(x.d));
        check_eq("sb_err", 64'(err), 64'(x.e));
        check_eq("sb_ans", ans, x.a);
        check_eq("gnt_low_at_done", 64'(gnt), 64'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, ns, nr;
    logic [NREQ-1:0] eg;
    rst = 1'b1; req = 4'b0000; e_in = 64'd0; exp_ans = 64'd0; stub_lat = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_exp_rst", 64'(exp_rst), 64'd1);
    check_eq("rst_gnt", 64'(gnt), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    check_eq("rst_ans", ans, 64'd0);
    check_eq("rst_start", 64'(exp_start), 64'd0);
    check_eq("rst_exp_e", exp_e, 64'd0);
    check_eq("rst_e_idx", 64'(exp_e_idx), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rel_exp_rst", 64'(exp_rst), 64'd0);

    // Single job on requester 0
    stub_lat = 20; exp_ans = 64'h1234; req = 4'b0001; e_in = 64'h10001;
    sb.push_back('{4'b0001, 1'b0, 64'h1234});
    @(negedge clk);
    check_eq("single_gnt_t1", 64'(gnt), 64'h1);
    @(negedge clk);
    check_eq("single_exp_e", exp_e, 64'h10001);
    e_in = 64'hDEAD;
    @(negedge clk);
    check_eq("single_exp_rst_t3", 64'(exp_rst), 64'd1);
    check_eq("single_start_t3", 64'(exp_start), 64'd0);
    check_eq("single_e_idx", 64'(exp_e_idx), 64'd16);
    check_eq("single_exp_e_hold", exp_e, 64'h10001);
    @(negedge clk);
    check_eq("single_exp_rst_t4", 64'(exp_rst), 64'd0);
    check_eq("single_start_t4", 64'(exp_start), 64'd1);
    s = cyc;
    req = 4'b0000;
    @(negedge clk);
    check_eq("single_start_t5", 64'(exp_start), 64'd0);
    wait_done(40);
    check_eq("single_done_cycle", 64'(cyc), 64'(s + 21));
    check_eq("single_ans", ans, 64'h1234);
    @(negedge clk);
    check_eq("single_done_pulse", 64'(done), 64'd0);

    // Rejected exponent on requester 2
    ns = n_start; nr = n_erst;
    req = 4'b0100; e_in = 64'd1;
    sb.push_back('{4'b0100, 1'b1, 64'h1234});
    @(negedge clk);
    check_eq("bad_gnt", 64'(gnt), 64'h4);
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    check_eq("bad_done_t3", 64'(done), 64'h4);
    check_eq("bad_err_t3", 64'(err), 64'd1);
    repeat (3) @(negedge clk);
    check_eq("bad_no_start", 64'(n_start), 64'(ns));
    check_eq("bad_no_exp_rst", 64'(n_erst), 64'(nr));
    check_eq("bad_ans_hold", ans, 64'h1234);

    // Sticky stop: job 1 leaves stop high, job 2 must wait for its own rising edge
    stub_lat = 5; exp_ans = 64'hAAAA; req = 4'b0001; e_in = 64'h7;
    sb.push_back('{4'b0001, 1'b0, 64'hAAAA});
    wait_gnt(10);
    req = 4'b0000;
    wait_done(40);
    repeat (3) @(negedge clk);
    check_eq("sticky_stop_high", 64'(exp_stop), 64'd1);
    stub_lat = 8; exp_ans = 64'hBBBB; req = 4'b0010; e_in = 64'hFF;
    sb.push_back('{4'b0010, 1'b0, 64'hBBBB});
    @(negedge clk);
    check_eq("sticky_gnt", 64'(gnt), 64'h2);
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    check_eq("sticky_stop_in_clr", 64'(exp_stop), 64'd1);
    check_eq("sticky_e_idx", 64'(exp_e_idx), 64'd7);
    @(negedge clk);
    check_eq("sticky_start", 64'(exp_start), 64'd1);
    s = cyc;
    wait_done(40);
    check_eq("sticky_done_cycle", 64'(cyc), 64'(s + 9));
    check_eq("sticky_ans", ans, 64'hBBBB);

    // Timeout with a stub that never stops
    @(negedge clk);
    stub_lat = 0; req = 4'b1000; e_in = 64'h3;
    sb.push_back('{4'b1000, 1'b1, 64'hBBBB});
    @(negedge clk);
    req = 4'b0000;
    repeat (3) @(negedge clk);
    check_eq("to_start", 64'(exp_start), 64'd1);
    s = cyc;
    wait_done(150);
    check_eq("to_done_cycle", 64'(cyc), 64'(s + 100));
    check_eq("to_err", 64'(err), 64'd1);
    @(negedge clk);
    check_eq("to_gnt_after", 64'(gnt), 64'd0);

    // Fairness with all requesters held
    stub_lat = 5; exp_ans = 64'h5555; e_in = 64'h3; req = 4'b1111;
    for (int j = 0; j < 6; j++) sb.push_back('{4'(1) << (j % 4), 1'b0, 64'h5555});
    for (int j = 0; j < 6; j++) begin
      wait_gnt(20);
      eg = 4'(1) << (j % 4);
      check_eq("fair_gnt", 64'(gnt), 64'(eg));
      if (j == 5) req = 4'b0000;
      wait_done(30);
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    check_eq("fair_idle", 64'(gnt), 64'd0);

    // Reset in the middle of RUN
    stub_lat = 0; req = 4'b0001; e_in = 64'h10001;
    repeat (4) @(negedge clk);
    check_eq("mid_start", 64'(exp_start), 64'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_exp_rst", 64'(exp_rst), 64'd1);
    check_eq("mid_rst_gnt", 64'(gnt), 64'd0);
    check_eq("mid_rst_ans", ans, 64'd0);
    check_eq("mid_rst_exp_e", exp_e, 64'd0);
    check_eq("mid_rst_e_idx", 64'(exp_e_idx), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; req = 4'b1001; stub_lat = 3; exp_ans = 64'h77; e_in = 64'h5;
    sb.push_back('{4'b0001, 1'b0, 64'h77});
    @(negedge clk);
    check_eq("post_rst_gnt", 64'(gnt), 64'h1);
    check_eq("post_rst_exp_rst", 64'(exp_rst), 64'd0);
    req = 4'b0000;
    wait_done(30);
    repeat (3) @(negedge clk);
    check_eq("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rsa_exp_arbiter.md
# rsa_exp_arbiter

Round-robin arbiter and job sequencer that shares one modular-exponentiation engine between `NREQ` requesters. It sits between the requester ports and the exponentiation engine's `start`/`e`/`e_idx`/`stop`/`ans` pins. For each granted job it captures the exponent, derives the MSB index, clears and starts the engine, and watches for completion or timeout. It then returns the result to the granted requester with a one-cycle `done` pulse.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `BITLEN`, 512: exponent and result width.
- `LOG_BITLEN`, 9: width of `exp_e_idx`.
- `TIMEOUT`, 2000000: maximum cycles allowed in RUN before the job is aborted.
- `TBITS`, 21: timeout counter width; `2^TBITS > TIMEOUT`.
- `clk`, in, 1: clock; all logic on posedge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `req`, in, `NREQ`: level requests, one bit per requester.
- `e_in`, in, `BITLEN`: shared exponent bus, driven by the granted requester.
- `gnt`, out, `NREQ`: one-hot grant, held for the whole job.
- `done`, out, `NREQ`: one-cycle completion pulse to the granted requester.
- `err`, out, 1: high together with `done` when the job failed.
- `ans`, out, `BITLEN`: result, valid while `done` is high, held until the next `done`.
- `exp_rst`, out, 1: engine clear pulse.
- `exp_start`, out, 1: engine start pulse.
- `exp_e`, out, `BITLEN`: captured exponent.
- `exp_e_idx`, out, `LOG_BITLEN`: MSB index of `exp_e`.
- `exp_stop`, in, 1: engine done. Sticky high until the engine is cleared.
- `exp_ans`, in, `BITLEN`: engine result.

## Operation
- All outputs are registered.
- Reset values:
  - `exp_rst`=1. It is released on the first clock edge after `rst` falls, so the engine is held cleared during reset.
  - Everything else is 0: `gnt`, `done`, `err`, `ans`, `exp_start`, `exp_e`, `exp_e_idx`.
  - State = IDLE; round-robin pointer `last` = `NREQ-1`, so requester 0 wins first.
- IDLE: if `req` is nonzero, pick the first set bit searching upward from `last+1` with wrap. Set `gnt` one-hot and go to LOAD.
- LOAD: capture `exp_e <= e_in`; go to SCAN.
- SCAN: one-cycle priority encode of `exp_e`.
  - If `exp_e < 2`, go to DONE with `err` (the engine cannot run with `e_idx = 0`).
  - Otherwise set `exp_e_idx` to the MSB index, set `exp_rst <= 1`, and go to CLR.
- CLR: `exp_rst` is high for exactly this cycle. Set `exp_start <= 1`, clear the timer and `stop_q`, and go to RUN.
- RUN:
  - `exp_start` is high during the first RUN cycle only.
  - Done condition is the rising edge `exp_stop && !stop_q`, with `stop_q` registered each cycle. On it, go to DONE with ok.
  - Otherwise the timer increments. When the timer reaches `TIMEOUT-1` without a done, go to DONE with `err`.
  - If the rising edge and timeout coincide, the rising edge wins (ok).
- DONE, one cycle:
  - `done[g] = 1` for the granted index g.
  - `err` = failure flag.
  - `ans <= exp_ans` on ok; on `err`, `ans` is unchanged.
  - `gnt` drops to 0, `last <= g`, next state IDLE.
- Requester rules:
  - Dropping `req` mid-job does not abort the job; it completes and pulses `done`.
  - A requester re-requests by keeping or reasserting `req` after `done`.
- Asserting `rst` in any state returns immediately to the reset values. The engine is re-cleared via `exp_rst` = 1.
- `e_in` is only sampled in LOAD; its value at other times is ignored.

## Timing
- Cycle at which IDLE sees `req` = T. Then:
  - `gnt` high at T+1 (LOAD).
  - `exp_e` valid at T+2.
  - `exp_rst` high at T+3 (CLR).
  - `exp_start` high at T+4 (first RUN cycle).
  - `exp_e` and `exp_e_idx` are stable from T+3 until the next job.
- Ok job: if the engine's stop rises at cycle R ≥ T+5, `done`/`ans` appear at R+1. `gnt` is low from R+1.
- Rejected exponent (`e_in < 2`): `done` and `err` at T+3. No `exp_rst` or `exp_start` is issued.
- Timeout: `done` and `err` at T+4+`TIMEOUT`.
- Back-to-back jobs: the minimum gap from one `done` to the next `gnt` is 1 cycle (the IDLE cycle).
- Overhead per job: 4 cycles plus engine latency plus 1.

## Test plan
- Single job: `req`=0001, `e_in`=0x10001, stub engine raises stop 20 cycles after start with `exp_ans`=0x1234. Required: `gnt`=0001 at T+1, `exp_e_idx`=16, one-cycle `exp_rst` then `exp_start`, `done`=0001 with `ans`=0x1234, `err`=0.
- Fairness: `req`=1111 held, stub latency 5. Required: grant order 0,1,2,3,0,1, with `gnt` always one-hot.
- Bad exponent: `e_in`=1 on requester 2. Required: `done`=0100 and `err`=1 at T+3, `exp_start` never asserted, `ans` unchanged.
- Timeout: `TIMEOUT`=100, stub never raises stop. Required: `done`+`err` exactly 100 cycles after the `exp_start` cycle, then `gnt`=0.
- Sticky stop: the stub keeps stop high after job 1 until `exp_rst` arrives; job 2 is requested. Required: no `done` before job 2's new rising edge, and `ans` equals job 2's value.
- Reset mid-RUN: assert `rst` during RUN. Required: all outputs reset immediately with `exp_rst`=1. After release, with `req`=1001, `gnt`=0001.
